// File: rtl/hub75_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hub75_pkg
// Description : Shared types and constants for the HUB75 scan-out engine.
// Revision    : 1.0
// ============================================================================
package hub75_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_BLANK = 3'd4,
        ST_LATCH = 3'd5,
        ST_ON    = 3'd6
    } state_t;

    // Pixel byte layout: low nibble-ish triplet is the top half, next triplet the bottom half
    localparam int c_bit_r1 = 0;
    localparam int c_bit_g1 = 1;
    localparam int c_bit_b1 = 2;
    localparam int c_bit_r2 = 3;
    localparam int c_bit_g2 = 4;
    localparam int c_bit_b2 = 5;

    localparam int c_def_cols      = 64;
    localparam int c_def_row_addrs = 16;
    localparam int c_def_on_cycles = 64;

endpackage
`default_nettype wire

// File: rtl/hub75_scanout.sv
`default_nettype none
// ============================================================================
// Module      : hub75_scanout
// Description : Framebuffer read-side engine driving HUB75 panel pins.
// Revision    : 1.0
// ============================================================================
module hub75_scanout
    import hub75_pkg::*;
#(
    parameter int COLS       = c_def_cols,
    parameter int ROW_ADDRS  = c_def_row_addrs,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int ON_CYCLES  = c_def_on_cycles
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    output logic [ADDR_WIDTH-1:0]        read_addr,
    output logic                         read_en,
    input  logic [DATA_WIDTH-1:0]        read_data,
    output logic [2:0]                   hub_rgb1,
    output logic [2:0]                   hub_rgb2,
    output logic                         hub_clk,
    output logic                         hub_lat,
    output logic                         hub_oe_n,
    output logic [$clog2(ROW_ADDRS)-1:0] hub_row,
    output logic                         frame_done
);

    localparam int c_col_w = $clog2(COLS);
    localparam int c_row_w = $clog2(ROW_ADDRS);
    localparam int c_on_w  = $clog2(ON_CYCLES + 1);

    localparam logic [c_col_w-1:0] c_last_col = c_col_w'(COLS - 1);
    localparam logic [c_row_w-1:0] c_last_row = c_row_w'(ROW_ADDRS - 1);
    localparam logic [c_on_w-1:0]  c_last_on  = c_on_w'(ON_CYCLES - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [c_col_w-1:0]   r_col;
    logic [c_row_w-1:0]   r_row;
    logic [c_on_w-1:0]    r_on_cnt;
    logic [2:0]           r_hub_rgb1;
    logic [2:0]           r_hub_rgb2;
    logic                 r_hub_clk;
    logic [c_row_w-1:0]   r_hub_row;
    logic                 w_last_col;
    logic                 w_last_row;
    logic                 w_last_on;
    logic [ADDR_WIDTH-1:0] w_pixel_addr;
    logic                 w_unused_data;

    assign w_last_col   = (r_col == c_last_col);
    assign w_last_row   = (r_row == c_last_row);
    assign w_last_on    = (r_on_cnt == c_last_on);
    assign w_pixel_addr = ADDR_WIDTH'(r_row) * ADDR_WIDTH'(COLS) + ADDR_WIDTH'(r_col);
    assign w_unused_data = &{1'b0, read_data};

    assign hub_rgb1 = r_hub_rgb1;
    assign hub_rgb2 = r_hub_rgb2;
    assign hub_clk  = r_hub_clk;
    assign hub_row  = r_hub_row;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Strobes that must line up with the state cycle itself are decoded here
    always_comb begin
        w_state_next = r_state;
        read_en      = 1'b0;
        read_addr    = '0;
        hub_lat      = 1'b0;
        hub_oe_n     = 1'b1;
        frame_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                read_en      = 1'b1;
                read_addr    = w_pixel_addr;
                w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                w_state_next = w_last_col ? ST_BLANK : ST_FETCH;
            end
            ST_BLANK: begin
                w_state_next = ST_LATCH;
            end
            ST_LATCH: begin
                hub_lat      = 1'b1;
                w_state_next = ST_ON;
            end
            ST_ON: begin
                hub_oe_n = 1'b0;
                if (w_last_on) begin
                    frame_done   = w_last_row;
                    w_state_next = enable ? ST_FETCH : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Shift clock trails SHIFT by one cycle so colour has a full clock of setup and hold
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_col      <= '0;
            r_row      <= '0;
            r_on_cnt   <= '0;
            r_hub_rgb1 <= '0;
            r_hub_rgb2 <= '0;
            r_hub_clk  <= 1'b0;
            r_hub_row  <= '0;
        end else begin
            r_hub_clk <= (r_state == ST_SHIFT);
            case (r_state)
                ST_LOAD: begin
                    r_hub_rgb1 <= {read_data[c_bit_b1], read_data[c_bit_g1], read_data[c_bit_r1]};
                    r_hub_rgb2 <= {read_data[c_bit_b2], read_data[c_bit_g2], read_data[c_bit_r2]};
                end
                ST_SHIFT: begin
                    r_col <= w_last_col ? '0 : r_col + 1'b1;
                end
                ST_BLANK: begin
                    r_hub_row <= r_row;
                    r_on_cnt  <= '0;
                end
                ST_ON: begin
                    if (w_last_on) begin
                        r_on_cnt <= '0;
                        r_row    <= w_last_row ? '0 : r_row + 1'b1;
                    end else begin
                        r_on_cnt <= r_on_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hub75_scanout.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_hub75_scanout
// Description : Directed self-checking bench for hub75_scanout.
// Revision    : 1.0
// ============================================================================
module tb_hub75_scanout;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [9:0] read_addr;
    logic       read_en;
    logic [7:0] read_data;
    logic [2:0] hub_rgb1;
    logic [2:0] hub_rgb2;
    logic       hub_clk;
    logic       hub_lat;
    logic       hub_oe_n;
    logic [3:0] hub_row;
    logic       frame_done;

    logic [7:0] mem [0:1023];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hub75_scanout dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .read_addr  (read_addr),
        .read_en    (read_en),
        .read_data  (read_data),
        .hub_rgb1   (hub_rgb1),
        .hub_rgb2   (hub_rgb2),
        .hub_clk    (hub_clk),
        .hub_lat    (hub_lat),
        .hub_oe_n   (hub_oe_n),
        .hub_row    (hub_row),
        .frame_done (frame_done)
    );

    // Synchronous-read RAM: data valid the cycle after read_en
    always @(posedge clk) begin
        if (read_en) read_data <= mem[read_addr];
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1 && (hub_clk === 1'b1 || hub_lat === 1'b1)) begin
            n_cmp++;
            assert (hub_oe_n === 1'b1) else begin
                n_err++;
                $error("FAIL oe_overlap: observed oe_n=%0b expected 1 (clk=%0b lat=%0b)", hub_oe_n, hub_clk, hub_lat);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Entered at the sampling point of a row's first FETCH cycle; leaves at the next row's first cycle
    task automatic run_row(input int row, input int drop_at);
        int clk_err = 0;
        int pulses  = 0;
        int rd_err  = 0;
        int rgb_err = 0;
        int lat_cnt = 0;
        int lat_idx = -1;
        int lat_row = -1;
        int oe_err  = 0;
        int fd_cnt  = 0;
        int fd_idx  = -1;
        int a;
        logic exp_clk;
        logic exp_rd;
        chk($sformatf("row%0d_start_en", row), read_en, 1);
        chk($sformatf("row%0d_start_addr", row), read_addr, row * 64);
        for (int c = 0; c < 258; c++) begin
            if (c == drop_at) enable = 1'b0;
            exp_clk = (c > 0 && c <= 192 && (c % 3) == 0);
            if (hub_clk !== exp_clk) clk_err++;
            if (hub_clk === 1'b1) pulses++;
            exp_rd = (c < 192 && (c % 3) == 0);
            if (read_en !== exp_rd) rd_err++;
            else if (exp_rd && read_addr !== 10'(row * 64 + c / 3)) rd_err++;
            if (c >= 2 && c <= 193) begin
                a = row * 64 + (c - 2) / 3;
                if (hub_rgb1 !== mem[a][2:0] || hub_rgb2 !== mem[a][5:3]) rgb_err++;
            end
            if (hub_lat === 1'b1) begin
                lat_cnt++;
                lat_idx = c;
                lat_row = int'(hub_row);
            end
            if (hub_oe_n !== (c < 194)) oe_err++;
            if (frame_done === 1'b1) begin
                fd_cnt++;
                fd_idx = c;
            end
            @(negedge clk);
        end
        chk($sformatf("row%0d_clk_place_err", row), clk_err, 0);
        chk($sformatf("row%0d_clk_pulses", row), pulses, 64);
        chk($sformatf("row%0d_read_err", row), rd_err, 0);
        chk($sformatf("row%0d_rgb_err", row), rgb_err, 0);
        chk($sformatf("row%0d_lat_cnt", row), lat_cnt, 1);
        chk($sformatf("row%0d_lat_idx", row), lat_idx, 193);
        chk($sformatf("row%0d_lat_row", row), lat_row, row);
        chk($sformatf("row%0d_oe_err", row), oe_err, 0);
        chk($sformatf("row%0d_fd_cnt", row), fd_cnt, (row == 15) ? 1 : 0);
        if (row == 15) chk("row15_fd_idx", fd_idx, 257);
    endtask

    initial begin
        int idle_err;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
        mem[0] = 8'h2a;
        mem[1] = 8'hc0;
        read_data = 8'h00;
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_read_en", read_en, 0);
        chk("rst_read_addr", read_addr, 0);
        chk("rst_oe_n", hub_oe_n, 1);
        chk("rst_clk", hub_clk, 0);
        chk("rst_lat", hub_lat, 0);
        chk("rst_row", hub_row, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_rgb1", hub_rgb1, 0);
        chk("rst_rgb2", hub_rgb2, 0);

        // First pixel: 0x2a -> rgb1=010, rgb2=101 around the first shift clock
        reset_n = 1'b1;
        enable  = 1'b1;
        @(negedge clk);
        chk("p0_fetch_en", read_en, 1);
        chk("p0_fetch_addr", read_addr, 0);
        @(negedge clk);
        chk("p0_load_en", read_en, 0);
        @(negedge clk);
        chk("p0_setup_clk", hub_clk, 0);
        chk("p0_setup_rgb1", hub_rgb1, 3'b010);
        chk("p0_setup_rgb2", hub_rgb2, 3'b101);
        @(negedge clk);
        chk("p0_high_clk", hub_clk, 1);
        chk("p0_high_rgb1", hub_rgb1, 3'b010);
        chk("p0_high_rgb2", hub_rgb2, 3'b101);
        chk("p1_fetch_addr", read_addr, 1);
        @(negedge clk);
        chk("p0_hold_clk", hub_clk, 0);
        chk("p0_hold_rgb1", hub_rgb1, 3'b010);
        chk("p0_hold_rgb2", hub_rgb2, 3'b101);
        @(negedge clk);
        chk("p1_ign76_rgb1", hub_rgb1, 0);
        chk("p1_ign76_rgb2", hub_rgb2, 0);

        // Reset asserted while in SHIFT, held 3 clocks
        reset_n = 1'b0;
        @(negedge clk);
        chk("mrst_oe_n", hub_oe_n, 1);
        chk("mrst_clk", hub_clk, 0);
        chk("mrst_lat", hub_lat, 0);
        chk("mrst_row", hub_row, 0);
        chk("mrst_read_en", read_en, 0);
        chk("mrst_fd", frame_done, 0);
        repeat (2) @(negedge clk);
        chk("mrst_hold_read_en", read_en, 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 16; r++) run_row(r, -1);
        run_row(0, -1);
        run_row(1, -1);
        run_row(2, -1);
        run_row(3, 30);

        chk("idle_read_en", read_en, 0);
        chk("idle_oe_n", hub_oe_n, 1);
        idle_err = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (read_en !== 1'b0 || hub_oe_n !== 1'b1) idle_err++;
        end
        chk("idle_hold_err", idle_err, 0);

        enable = 1'b1;
        @(negedge clk);
        run_row(4, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
